// File: rtl/aes_pkg.sv
// Shared AES definitions: GF(2^8) arithmetic, byte/column geometry and FSM state type.
// Used by inv_mix_columns (build option INV_MIX_COLUMNS_DUAL_COL_EN) and its column datapath.
package aes_pkg;

    localparam int BYTE_W   = 8;
    localparam int ROWS     = 4;
    localparam int NUM_COLS = 4;
    localparam int COL_W    = BYTE_W * ROWS;
    localparam int BLOCK_W  = COL_W * NUM_COLS;

    localparam logic [1:0] LAST_COL = 2'd3;

    // Reduction term of x^8 + x^4 + x^3 + x + 1 once the x^8 bit has been shifted out.
    localparam logic [BYTE_W-1:0] GF_POLY = 8'h1B;

    // Row r of the inverse matrix applied as coefficients to rows r, r+1, r+2, r+3 (mod 4).
    localparam logic [BYTE_W-1:0] INV_COEF [ROWS] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COMPUTE,
        ST_OUTPUT
    } state_t;

    function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] b);
        return {b[BYTE_W-2:0], 1'b0} ^ (b[BYTE_W-1] ? GF_POLY : 8'h00);
    endfunction

    // Shift-and-add multiply; with a constant b this collapses to a short xtime/XOR chain.
    function automatic logic [BYTE_W-1:0] gf_mul(input logic [BYTE_W-1:0] a,
                                                  input logic [BYTE_W-1:0] b);
        logic [BYTE_W-1:0] acc;
        logic [BYTE_W-1:0] pw;
        acc = '0;
        pw  = a;
        for (int i = 0; i < BYTE_W; i++) begin
            if (b[i]) acc = acc ^ pw;
            pw = xtime(pw);
        end
        return acc;
    endfunction

endpackage

// File: rtl/inv_mix_column_word.sv
// Combinational InvMixColumns of one 32-bit column; byte r of the column is row r.
module inv_mix_column_word
    import aes_pkg::*;
(
    input  logic [COL_W-1:0] col_in,
    output logic [COL_W-1:0] col_out
);

    always_comb begin
        col_out = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int i = 0; i < ROWS; i++) begin
                col_out[r*BYTE_W +: BYTE_W] = col_out[r*BYTE_W +: BYTE_W]
                    ^ gf_mul(col_in[((r + i) % ROWS)*BYTE_W +: BYTE_W], INV_COEF[i]);
            end
        end
    end

endmodule

// File: rtl/inv_mix_columns.sv
// Iterative AES InvMixColumns: one column per cycle, or two with INV_MIX_COLUMNS_DUAL_COL_EN.
// Handshake: start is taken only while ready_out=1 (IDLE); valid_out pulses once per finished block.
module inv_mix_columns
    import aes_pkg::*;
(
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               start,
    input  logic [BLOCK_W-1:0] block_in,
    output logic               ready_out,
    output logic [BLOCK_W-1:0] result_out,
    output logic               valid_out
);

    state_t             state;
    state_t             state_nxt;
    logic [BLOCK_W-1:0] blk_q;
    logic [BLOCK_W-1:0] acc_q;
    logic [1:0]         col_idx;
    logic               cap_en;
    logic               step_en;
    logic               load_en;
    logic               last_step;
    logic [COL_W-1:0]   word_lo;

`ifdef INV_MIX_COLUMNS_DUAL_COL_EN
    localparam logic [1:0] COL_STEP = 2'd2;

    logic [1:0]       col_hi;
    logic [COL_W-1:0] word_hi;

    assign col_hi    = col_idx | 2'd1;
    assign last_step = (col_hi == LAST_COL);

    inv_mix_column_word u_word_lo (
        .col_in  (blk_q[{col_idx, 5'd0} +: COL_W]),
        .col_out (word_lo)
    );

    inv_mix_column_word u_word_hi (
        .col_in  (blk_q[{col_hi, 5'd0} +: COL_W]),
        .col_out (word_hi)
    );
`else
    localparam logic [1:0] COL_STEP = 2'd1;

    assign last_step = (col_idx == LAST_COL);

    inv_mix_column_word u_word_lo (
        .col_in  (blk_q[{col_idx, 5'd0} +: COL_W]),
        .col_out (word_lo)
    );
`endif

    // OUTPUT is the publish cycle: result_out/valid_out load on its closing edge,
    // which also returns to IDLE so the next block can be taken one cycle later.
    always_comb begin
        state_nxt = state;
        cap_en    = 1'b0;
        step_en   = 1'b0;
        load_en   = 1'b0;
        ready_out = 1'b0;
        unique case (state)
            ST_IDLE: begin
                ready_out = 1'b1;
                if (start) begin
                    cap_en    = 1'b1;
                    state_nxt = ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                step_en = 1'b1;
                if (last_step) state_nxt = ST_OUTPUT;
            end
            ST_OUTPUT: begin
                load_en   = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state      <= ST_IDLE;
            col_idx    <= '0;
            result_out <= '0;
            valid_out  <= 1'b0;
        end else begin
            state     <= state_nxt;
            valid_out <= load_en;
            if (cap_en)  col_idx    <= '0;
            if (step_en) col_idx    <= col_idx + COL_STEP;
            if (load_en) result_out <= acc_q;
        end
    end

    // Working registers need no reset: nothing reaches result_out without a fresh capture.
    always_ff @(posedge clk_in) begin
        if (cap_en) blk_q <= block_in;
        if (step_en) begin
            acc_q[{col_idx, 5'd0} +: COL_W] <= word_lo;
`ifdef INV_MIX_COLUMNS_DUAL_COL_EN
            acc_q[{col_hi, 5'd0} +: COL_W] <= word_hi;
`endif
        end
    end

endmodule

// File: tb/tb_inv_mix_columns.sv
// Self-checking bench for inv_mix_columns; expectations come from a forward MixColumns model,
// directed AES vectors and a cycle-level model of acceptance, latency and reset.
module tb_inv_mix_columns;

`ifdef INV_MIX_COLUMNS_DUAL_COL_EN
    localparam int LAT    = 3;
    localparam int PERIOD = 4;
`else
    localparam int LAT    = 5;
    localparam int PERIOD = 6;
`endif

    logic         clk_in = 1'b0;
    logic         rst_in;
    logic         start;
    logic [127:0] block_in;
    logic         ready_out;
    logic [127:0] result_out;
    logic         valid_out;

    inv_mix_columns dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .start      (start),
        .block_in   (block_in),
        .ready_out  (ready_out),
        .result_out (result_out),
        .valid_out  (valid_out)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    logic [127:0] exp_q[$];
    int           due_q[$];
    int           valid_cyc_q[$];
    logic [127:0] drv_exp;
    logic [127:0] last_res;
    int           busy;
    int           n_acc;
    int           n_tests;
    int           n_fail;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul_ref(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--)
            if (p[i]) p = p ^ (16'h11B << (i - 8));
        return p[7:0];
    endfunction

    // Forward MixColumns: the DUT must undo exactly this.
    function automatic logic [127:0] mix_ref(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   v;
        logic [7:0]   k;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                v = '0;
                for (int i = 0; i < 4; i++) begin
                    k = (i == 0) ? 8'h02 : (i == 1) ? 8'h03 : 8'h01;
                    v = v ^ gmul_ref(s[8*(4*c + (r + i) % 4) +: 8], k);
                end
                o[8*(4*c + r) +: 8] = v;
            end
        end
        return o;
    endfunction

    function automatic logic [31:0] mk_col(input logic [7:0] r0, input logic [7:0] r1,
                                           input logic [7:0] r2, input logic [7:0] r3);
        return {r3, r2, r1, r0};
    endfunction

    function automatic logic [127:0] rand_blk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Advance one clock: predict what the coming edge does, then check outputs at the negedge.
    task automatic tick();
        logic exp_valid;
        if (rst_in) begin
            exp_q.delete();
            due_q.delete();
            busy     = 0;
            last_res = '0;
        end else if (busy > 0) begin
            busy--;
        end else if (start) begin
            exp_q.push_back(drv_exp);
            due_q.push_back(cyc + 1 + LAT);
            busy = PERIOD - 1;
            n_acc++;
        end
        @(negedge clk_in);
        exp_valid = (due_q.size() > 0) && (due_q[0] == cyc);
        check("ready_out", ready_out, busy == 0);
        check("valid_out", valid_out, exp_valid);
        if (exp_valid) begin
            last_res = exp_q.pop_front();
            due_q.delete(0);
            valid_cyc_q.push_back(cyc);
            check("result_out", result_out, last_res);
        end else begin
            check("result_hold", result_out, last_res);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic s, input logic [127:0] blk, input logic [127:0] exp);
        start    = s;
        block_in = blk;
        drv_exp  = exp;
    endtask

    task automatic send_block(input logic [127:0] blk, input logic [127:0] exp);
        drive(1'b1, blk, exp);
        tick();
        drive(1'b0, rand_blk(), rand_blk());
        repeat (PERIOD) tick();
    endtask

    task automatic send_orig(input logic [127:0] orig);
        send_block(mix_ref(orig), orig);
    endtask

    logic [127:0] blk_a;
    logic [127:0] blk_b;
    logic [127:0] orig;
    int           guard;
    int           target;

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        n_acc    = 0;
        busy     = 0;
        last_res = '0;
        rst_in   = 1'b1;
        drive(1'b0, '0, '0);
        tick();
        tick();
        rst_in = 1'b0;
        tick();

        // Known AES column vectors
        blk_a = {4{mk_col(8'h8e, 8'h4d, 8'ha1, 8'hbc)}};
        blk_b = {4{mk_col(8'hdb, 8'h13, 8'h53, 8'h45)}};
        send_block(blk_a, blk_b);
        blk_a = {mk_col(8'hc6, 8'hc6, 8'hc6, 8'hc6), mk_col(8'h01, 8'h01, 8'h01, 8'h01),
                 mk_col(8'h4d, 8'h7e, 8'hbd, 8'hf8), mk_col(8'hd5, 8'hd5, 8'hd7, 8'hd6)};
        blk_b = {mk_col(8'hc6, 8'hc6, 8'hc6, 8'hc6), mk_col(8'h01, 8'h01, 8'h01, 8'h01),
                 mk_col(8'h2d, 8'h26, 8'h31, 8'h4c), mk_col(8'hd4, 8'hd4, 8'hd4, 8'hd5)};
        send_block(blk_a, blk_b);
        send_orig('0);
        send_orig({128{1'b1}});

        // Reset during COMPUTE (edge N+2)
        orig = rand_blk();
        drive(1'b1, mix_ref(orig), orig);
        tick();
        drive(1'b0, rand_blk(), rand_blk());
        tick();
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        repeat (PERIOD + 2) tick();

        // Reset on the publish edge; reset also wins over a simultaneous start
        orig = rand_blk();
        drive(1'b1, mix_ref(orig), orig);
        tick();
        drive(1'b0, rand_blk(), rand_blk());
        repeat (LAT - 1) tick();
        rst_in = 1'b1;
        orig = rand_blk();
        drive(1'b1, mix_ref(orig), orig);
        tick();
        rst_in = 1'b0;
        drive(1'b0, rand_blk(), rand_blk());
        repeat (PERIOD + 2) tick();

        // Busy starts with changing block_in are ignored; start at N+PERIOD is taken
        send_orig(rand_blk());
        orig = rand_blk();
        drive(1'b1, mix_ref(orig), orig);
        tick();
        for (int k = 1; k < PERIOD; k++) begin
            orig = rand_blk();
            drive(1'b1, mix_ref(orig), orig);
            tick();
        end
        orig = rand_blk();
        drive(1'b1, mix_ref(orig), orig);
        tick();
        drive(1'b0, rand_blk(), rand_blk());
        repeat (PERIOD + 1) tick();

        // Back-to-back with start held high
        valid_cyc_q.delete();
        for (int k = 0; k < 5 * PERIOD; k++) begin
            orig = rand_blk();
            drive(1'b1, mix_ref(orig), orig);
            tick();
        end
        drive(1'b0, rand_blk(), rand_blk());
        repeat (PERIOD + 1) tick();
        check("b2b_count", valid_cyc_q.size(), 5);
        for (int k = 1; k < valid_cyc_q.size(); k++)
            check("b2b_period", valid_cyc_q[k] - valid_cyc_q[k-1], PERIOD);

        // Random stream with random start density
        target = n_acc + 1000;
        guard  = 0;
        while (n_acc < target && guard < 20000) begin
            orig = rand_blk();
            drive($urandom_range(0, 3) != 0, mix_ref(orig), orig);
            tick();
            guard++;
        end
        check("random_blocks", n_acc, target);

        drive(1'b0, '0, '0);
        guard = 0;
        while (due_q.size() > 0 && guard < 4 * PERIOD) begin
            tick();
            guard++;
        end
        check("drain", due_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/inv_mix_columns.md
INV_MIX_COLUMNS -- requirements
Module: inv_mix_columns

Interface
REQ-001 SHALL have no parameters; the only build-time option is the macro in Configuration.
REQ-002 clk_in  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_in  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  new block present on block_in; accepted only when ready_out=1.
REQ-005 block_in  input  128  AES state; byte k = bits [8k+7:8k]; column c = bytes 4c..4c+3 (row 0..3).
REQ-006 ready_out  output  1  high only in IDLE; start is accepted only while high.
REQ-007 result_out  output  128  InvMixColumns of the accepted block, same byte/column mapping.
REQ-008 valid_out  output  1  one-cycle pulse marking a new result_out.

Function
REQ-009 SHALL implement the FSM states IDLE, COMPUTE and OUTPUT.
REQ-010 IDLE: ready_out=1, valid_out=0; start=1 captures block_in into an internal register, clears col_idx to 0 and goes to COMPUTE.
REQ-011 COMPUTE: ready_out=0; each cycle transforms column col_idx of the captured block and increments col_idx.
REQ-012 Column transform: out_r = 0e*a_r ^ 0b*a_(r+1) ^ 0d*a_(r+2) ^ 09*a_(r+3), with row index r+i taken mod 4.
REQ-013 GF(2^8) multiplies SHALL use polynomial 0x11B, built from xtime chains; no lookup tables.
REQ-014 After the last column, result_out SHALL load all 16 result bytes in one update, valid_out SHALL go to 1, and the FSM SHALL enter OUTPUT.
REQ-015 OUTPUT lasts exactly one cycle: valid_out returns to 0 and the FSM returns to IDLE.
REQ-016 Latency: start sampled at edge N; result_out and valid_out update at edge N+5 (default build).
REQ-017 result_out SHALL hold its value until the next valid_out pulse.
REQ-018 start while ready_out=0, including the OUTPUT cycle, SHALL be ignored; block_in changes after capture SHALL have no effect.
REQ-019 Back-to-back: the next start can be accepted one cycle after the valid_out pulse, giving 1 block per 6 cycles.
REQ-020 col_idx SHALL be 2 bits wide, and the last-column test SHALL use col_idx==3 rather than overflow.

Reset
REQ-021 rst_in=1 at any edge forces: state=IDLE, col_idx=0, result_out=0, valid_out=0, ready_out=1 on the following cycle.
REQ-022 Reset during COMPUTE or OUTPUT SHALL abort the block with no valid_out pulse; rst_in has priority over start.

Configuration
REQ-023 Macro INV_MIX_COLUMNS_DUAL_COL_EN.
REQ-024 When defined: two columns transformed per COMPUTE cycle, col_idx steps by 2, latency is N+3, throughput is 1 block per 4 cycles.
REQ-025 When undefined: one column per cycle, per REQ-016 and REQ-019.
REQ-026 Results SHALL be bit-identical in both builds.

Structure
REQ-027 Shared package aes_pkg SHALL hold: the xtime and gf_mul functions, the byte/column index constants, and the FSM state typedef.
REQ-028 Single-column datapath SHALL be sub-module inv_mix_column_word: 32-bit in, 32-bit out, combinational.
REQ-029 The dual build SHALL instantiate inv_mix_column_word twice.

Verification
REQ-030 Columns of 8e 4d a1 bc in all four positions -> each column db 13 53 45; valid_out high one cycle at N+5.
REQ-031 Columns d5 d5 d7 d6, 4d 7e bd f8, 01 01 01 01, c6 c6 c6 c6 -> d4 d4 d4 d5, 2d 26 31 4c, 01 01 01 01, c6 c6 c6 c6.
REQ-032 Reset mid-op: start, then rst_in at N+2 -> no valid_out, result_out=0, ready_out=1 at N+3.
REQ-033 Busy-start: a second start at N+1..N+5 with a different block_in -> ignored; the first result only; next start at N+6 is accepted.
REQ-034 Random stream: 1000 random blocks through mix_columns model then DUT -> original block recovered; both builds, latency 5/3.
REQ-035 Back-to-back starts held high continuously -> valid_out period 6 cycles (default) / 4 cycles (dual).
